// File: rtl/pipe_ctrl_if.sv
// Handshake bundle between the 5-stage datapath and its sequencing controller.
// The controller owns the per-stage valid bits and load enables; the datapath
// supplies the ID-stage operand/destination info and the MEM wait signal.
interface pipe_ctrl_if #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
);
    // ID-stage instruction info and MEM backpressure (datapath -> controller)
    logic [AW-1:0]    ds_rj;
    logic             ds_rj_used;
    logic [AW-1:0]    ds_rkd;
    logic             ds_rkd_used;
    logic [AW-1:0]    ds_dest;
    logic             ds_gr_we;
    logic             ds_br_taken;
    logic             mem_wait;

    // Stage status and pipeline-register enables (controller -> datapath)
    logic             fs_valid;
    logic             ds_valid;
    logic             es_valid;
    logic             ms_valid;
    logic             ws_valid;
    logic             pc_en;
    logic             ds_en;
    logic             es_en;
    logic             ms_en;
    logic             ws_en;
    logic             br_cancel;
    logic             ds_stall;
    logic [CNT_W-1:0] retire_cnt;
    logic [CNT_W-1:0] stall_cnt;

    // Controller side: sequences the pipeline.
    modport master (
        input  ds_rj, ds_rj_used, ds_rkd, ds_rkd_used, ds_dest, ds_gr_we,
               ds_br_taken, mem_wait,
        output fs_valid, ds_valid, es_valid, ms_valid, ws_valid,
               pc_en, ds_en, es_en, ms_en, ws_en,
               br_cancel, ds_stall, retire_cnt, stall_cnt
    );

    // Datapath side: follows the enables and reports ID/MEM status.
    modport slave (
        output ds_rj, ds_rj_used, ds_rkd, ds_rkd_used, ds_dest, ds_gr_we,
               ds_br_taken, mem_wait,
        input  fs_valid, ds_valid, es_valid, ms_valid, ws_valid,
               pc_en, ds_en, es_en, ms_en, ws_en,
               br_cancel, ds_stall, retire_cnt, stall_cnt
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Sequencing controller for the 5-stage IF/ID/EX/MEM/WB pipeline.
// Keeps the stage valid bits, the valid/allowin chain, a destination
// scoreboard for RAW stalls (no forwarding), wrong-path cancellation on
// taken branches, and retire/stall performance counters.
module pipe_ctrl #(
    parameter int AW    = 5,
    parameter int CNT_W = 32
) (
    input  logic      clk,
    input  logic      reset,
    pipe_ctrl_if.master bus
);

    typedef struct packed {
        logic          gr_we;
        logic [AW-1:0] dest;
    } sb_entry_t;

    logic fs_valid, ds_valid, es_valid, ms_valid, ws_valid;
    logic fs_ready_go, ds_ready_go, es_ready_go, ms_ready_go, ws_ready_go;
    logic fs_allowin, ds_allowin, es_allowin, ms_allowin, ws_allowin;
    logic pc_en, ds_en, es_en, ms_en, ws_en;
    logic br_cancel, ds_stall, rj_hit, rkd_hit;

    sb_entry_t ds_entry, es_sb, ms_sb, ws_sb;

    logic [CNT_W-1:0] retire_cnt, stall_cnt;

    // A stage matches when it holds a live GPR write to register r.
    function automatic logic sb_hit(input logic [AW-1:0] r, input logic v, input sb_entry_t e);
        return v && e.gr_we && (e.dest == r);
    endfunction

    // Hazard detection, then the allowin chain resolved backwards from WB.
    always_comb begin
        // NOTE: every signal gets a default first so no path leaves one unassigned and infers a latch.
        rj_hit      = 1'b0;
        rkd_hit     = 1'b0;
        ds_stall    = 1'b0;
        fs_ready_go = 1'b1;
        ds_ready_go = 1'b1;
        es_ready_go = 1'b1;
        ms_ready_go = 1'b1;
        ws_ready_go = 1'b1;
        ws_allowin  = 1'b1;
        ms_allowin  = 1'b0;
        es_allowin  = 1'b0;
        ds_allowin  = 1'b0;
        fs_allowin  = 1'b0;
        ds_entry    = '{gr_we: bus.ds_gr_we, dest: bus.ds_dest};

        // WB also counts: its regfile write lands on the same edge the reader would sample.
        rj_hit  = (bus.ds_rj != '0) &&
                  (sb_hit(bus.ds_rj, es_valid, es_sb) ||
                   sb_hit(bus.ds_rj, ms_valid, ms_sb) ||
                   sb_hit(bus.ds_rj, ws_valid, ws_sb));
        rkd_hit = (bus.ds_rkd != '0) &&
                  (sb_hit(bus.ds_rkd, es_valid, es_sb) ||
                   sb_hit(bus.ds_rkd, ms_valid, ms_sb) ||
                   sb_hit(bus.ds_rkd, ws_valid, ws_sb));
        ds_stall = ds_valid && ((rj_hit && bus.ds_rj_used) || (rkd_hit && bus.ds_rkd_used));

        ds_ready_go = !ds_stall;
        ms_ready_go = !bus.mem_wait;

        ms_allowin = !ms_valid || (ms_ready_go && ws_allowin);
        es_allowin = !es_valid || (es_ready_go && ms_allowin);
        ds_allowin = !ds_valid || (ds_ready_go && es_allowin);
        fs_allowin = !fs_valid || (fs_ready_go && ds_allowin);
    end

    // Load enables and branch cancellation derived from the handshake chain.
    always_comb begin
        pc_en     = !reset && fs_allowin;
        ds_en     = fs_valid && fs_ready_go && ds_allowin;
        es_en     = ds_valid && ds_ready_go && es_allowin;
        ms_en     = es_valid && es_ready_go && ms_allowin;
        ws_en     = ms_valid && ms_ready_go && ws_allowin;
        // A stalled branch has not fired yet, so it cannot cancel.
        br_cancel = ds_valid && bus.ds_br_taken && ds_ready_go && es_allowin;
    end

    // Stage valid bits: each stage refills from its predecessor when it can accept.
    always_ff @(posedge clk) begin
        // NOTE: non-blocking so every stage samples its predecessor's pre-edge value.
        if (reset) begin
            fs_valid <= 1'b0;
            ds_valid <= 1'b0;
            es_valid <= 1'b0;
            ms_valid <= 1'b0;
            ws_valid <= 1'b0;
        end else begin
            if (fs_allowin) fs_valid <= 1'b1;
            if (ds_allowin) ds_valid <= fs_valid && fs_ready_go && !br_cancel;
            if (es_allowin) es_valid <= ds_valid && ds_ready_go;
            if (ms_allowin) ms_valid <= es_valid && es_ready_go;
            if (ws_allowin) ws_valid <= ms_valid && ms_ready_go;
        end
    end

    // Destination scoreboard following the instruction down EX/MEM/WB; empty slots read as zero.
    always_ff @(posedge clk) begin
        // NOTE: only three small entries, so they are reset like any control flop rather than left as uninitialised storage.
        if (reset) begin
            es_sb <= '0;
            ms_sb <= '0;
            ws_sb <= '0;
        end else begin
            if (es_allowin) es_sb <= es_en ? ds_entry : '0;
            if (ms_allowin) ms_sb <= ms_en ? es_sb : '0;
            if (ws_allowin) ws_sb <= ws_en ? ms_sb : '0;
        end
    end

    // Performance counters; they wrap naturally at 2^CNT_W.
    always_ff @(posedge clk) begin
        if (reset) begin
            retire_cnt <= '0;
            stall_cnt  <= '0;
        end else begin
            retire_cnt <= retire_cnt + CNT_W'(ws_valid);
            stall_cnt  <= stall_cnt + CNT_W'(ds_stall);
        end
    end

    assign bus.fs_valid   = fs_valid;
    assign bus.ds_valid   = ds_valid;
    assign bus.es_valid   = es_valid;
    assign bus.ms_valid   = ms_valid;
    assign bus.ws_valid   = ws_valid;
    assign bus.pc_en      = pc_en;
    assign bus.ds_en      = ds_en;
    assign bus.es_en      = es_en;
    assign bus.ms_en      = ms_en;
    assign bus.ws_en      = ws_en;
    assign bus.br_cancel  = br_cancel;
    assign bus.ds_stall   = ds_stall;
    assign bus.retire_cnt = retire_cnt;
    assign bus.stall_cnt  = stall_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: a cycle table covering fill, RAW stall,
// r0 writes, taken branches (free and stalled), then hand-written
// mem_wait backpressure and mid-run reset sequences.
module tb_pipe_ctrl;

    typedef struct {
        logic       rst;
        logic [4:0] rj;
        logic       rju;
        logic [4:0] rkd;
        logic       rku;
        logic [4:0] dest;
        logic       we;
        logic       br;
        logic       mw;
        logic [4:0] val;   // {fs,ds,es,ms,ws}_valid
        logic [4:0] en;    // {pc,ds,es,ms,ws}_en
        logic [1:0] fl;    // {br_cancel, ds_stall}
        int         ret;
        int         stl;
    } vec_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   passed = 0;
    int   total = 0;
    vec_t tbl[21];

    pipe_ctrl_if #(.AW(5), .CNT_W(32)) bus ();

    pipe_ctrl #(.AW(5), .CNT_W(32)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic vec_t mk(input logic rst, input logic [4:0] rj, input logic rju,
                                input logic [4:0] rkd, input logic rku, input logic [4:0] dest,
                                input logic we, input logic br, input logic mw,
                                input logic [4:0] val, input logic [4:0] en, input logic [1:0] fl,
                                input int ret, input int stl);
        vec_t v;
        v.rst = rst; v.rj = rj; v.rju = rju; v.rkd = rkd; v.rku = rku;
        v.dest = dest; v.we = we; v.br = br; v.mw = mw;
        v.val = val; v.en = en; v.fl = fl; v.ret = ret; v.stl = stl;
        return v;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Drive one cycle's inputs at the falling edge and check just after.
    task automatic apply(input vec_t v, input string tag);
        @(negedge clk);
        reset           = v.rst;
        bus.ds_rj       = v.rj;
        bus.ds_rj_used  = v.rju;
        bus.ds_rkd      = v.rkd;
        bus.ds_rkd_used = v.rku;
        bus.ds_dest     = v.dest;
        bus.ds_gr_we    = v.we;
        bus.ds_br_taken = v.br;
        bus.mem_wait    = v.mw;
        #1;
        check({tag, " valids"}, 32'({bus.fs_valid, bus.ds_valid, bus.es_valid,
                                     bus.ms_valid, bus.ws_valid}), 32'(v.val));
        check({tag, " enables"}, 32'({bus.pc_en, bus.ds_en, bus.es_en,
                                      bus.ms_en, bus.ws_en}), 32'(v.en));
        check({tag, " cancel/stall"}, 32'({bus.br_cancel, bus.ds_stall}), 32'(v.fl));
        check({tag, " retire_cnt"}, bus.retire_cnt, 32'(v.ret));
        check({tag, " stall_cnt"}, bus.stall_cnt, 32'(v.stl));
    endtask

    initial begin
        bus.ds_rj = 5'd1; bus.ds_rj_used = 1'b1; bus.ds_rkd = 5'd2; bus.ds_rkd_used = 1'b1;
        bus.ds_dest = 5'd3; bus.ds_gr_we = 1'b1; bus.ds_br_taken = 1'b0; bus.mem_wait = 1'b0;

        //             rst rj    u  rkd   u  dest  we br mw  valids    enables   fl     ret stl
        // Fill with independent ALU ops.
        tbl[0]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd3,  1, 0, 0, 5'b00000, 5'b10000, 2'b00, 0,  0);
        tbl[1]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd3,  1, 0, 0, 5'b10000, 5'b11000, 2'b00, 0,  0);
        tbl[2]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd4,  1, 0, 0, 5'b11000, 5'b11100, 2'b00, 0,  0);
        tbl[3]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd5,  1, 0, 0, 5'b11100, 5'b11110, 2'b00, 0,  0);
        tbl[4]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd6,  1, 0, 0, 5'b11110, 5'b11111, 2'b00, 0,  0);
        tbl[5]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd7,  1, 0, 0, 5'b11111, 5'b11111, 2'b00, 0,  0);
        // Producer of r9, then a consumer of r9: three stall cycles, three bubbles.
        tbl[6]  = mk(0, 5'd1,  1, 5'd2, 1, 5'd9,  1, 0, 0, 5'b11111, 5'b11111, 2'b00, 1,  0);
        tbl[7]  = mk(0, 5'd9,  1, 5'd2, 1, 5'd10, 1, 0, 0, 5'b11111, 5'b00011, 2'b01, 2,  0);
        tbl[8]  = mk(0, 5'd9,  1, 5'd2, 1, 5'd10, 1, 0, 0, 5'b11011, 5'b00001, 2'b01, 3,  1);
        tbl[9]  = mk(0, 5'd9,  1, 5'd2, 1, 5'd10, 1, 0, 0, 5'b11001, 5'b00000, 2'b01, 4,  2);
        tbl[10] = mk(0, 5'd9,  1, 5'd2, 1, 5'd10, 1, 0, 0, 5'b11000, 5'b11100, 2'b00, 5,  3);
        // Writer of r0, then a reader of r0: no stall.
        tbl[11] = mk(0, 5'd1,  1, 5'd2, 1, 5'd0,  1, 0, 0, 5'b11100, 5'b11110, 2'b00, 5,  3);
        tbl[12] = mk(0, 5'd0,  1, 5'd2, 1, 5'd13, 1, 0, 0, 5'b11110, 5'b11111, 2'b00, 5,  3);
        // Taken beq with no hazard: cancel one cycle, ID empty next, target in ID after two.
        tbl[13] = mk(0, 5'd1,  1, 5'd2, 1, 5'd0,  0, 1, 0, 5'b11111, 5'b11111, 2'b10, 5,  3);
        tbl[14] = mk(0, 5'd1,  1, 5'd2, 1, 5'd0,  0, 1, 0, 5'b10111, 5'b11011, 2'b00, 6,  3);
        // Target reads r13 (live in WB) but does not use rj: no stall.
        tbl[15] = mk(0, 5'd13, 0, 5'd2, 1, 5'd11, 1, 0, 0, 5'b11011, 5'b11101, 2'b00, 7,  3);
        // Taken branch that depends on r11: stall wins, cancel only when it fires.
        tbl[16] = mk(0, 5'd11, 1, 5'd2, 1, 5'd0,  0, 1, 0, 5'b11101, 5'b00010, 2'b01, 8,  3);
        tbl[17] = mk(0, 5'd11, 1, 5'd2, 1, 5'd0,  0, 1, 0, 5'b11010, 5'b00001, 2'b01, 9,  4);
        tbl[18] = mk(0, 5'd11, 1, 5'd2, 1, 5'd0,  0, 1, 0, 5'b11001, 5'b00000, 2'b01, 9,  5);
        tbl[19] = mk(0, 5'd11, 1, 5'd2, 1, 5'd0,  0, 1, 0, 5'b11000, 5'b11100, 2'b10, 10, 6);
        tbl[20] = mk(0, 5'd1,  1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b10100, 5'b11010, 2'b00, 10, 6);

        // State while held in reset.
        apply(mk(1, 5'd1, 1, 5'd2, 1, 5'd3, 1, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 0), "reset");

        for (int i = 0; i < 21; i++) apply(tbl[i], $sformatf("c%0d", i));

        // Refill, then hold a load in MEM with mem_wait for three cycles.
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b11010, 5'b11101, 2'b00, 10, 6), "c21");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b11101, 5'b11110, 2'b00, 10, 6), "c22");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b11110, 5'b11111, 2'b00, 11, 6), "c23");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 1, 5'b11111, 5'b00000, 2'b00, 11, 6), "mw1");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 1, 5'b11110, 5'b00000, 2'b00, 12, 6), "mw2");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 1, 5'b11110, 5'b00000, 2'b00, 12, 6), "mw3");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b11110, 5'b11111, 2'b00, 12, 6), "mw_release");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b11111, 5'b11111, 2'b00, 12, 6), "mw_refill");

        // Full pipeline with a live hazard on r12, reset asserted in the same cycle.
        apply(mk(1, 5'd12, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b11111, 5'b00011, 2'b01, 13, 6), "rst_hazard");
        apply(mk(1, 5'd12, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b00000, 5'b00000, 2'b00, 0, 0), "rst_cleared");
        apply(mk(0, 5'd1, 1, 5'd2, 1, 5'd12, 1, 0, 0, 5'b00000, 5'b10000, 2'b00, 0, 0), "rst_release");

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
